// File: rtl/omsp_viol_pkg.sv
// Shared definitions for the security-violation handler.
// No logic, constants and types only.
// No flow control.
package omsp_viol_pkg;

   // Handler FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_NOTIFY   = 2'd1,
      ST_WAIT_CLR = 2'd2,
      ST_RESET    = 2'd3
   } viol_state_e;

   // Word offsets from the block base
   localparam logic [1:0] REG_STATUS  = 2'd0;
   localparam logic [1:0] REG_PC_CAPT = 2'd1;
   localparam logic [1:0] REG_ID_CAPT = 2'd2;

   // Overflow flag position in STATUS
   localparam int OVF_BIT = 15;

   // Violation source indices in viol_src
   localparam int VIOL_ATOM  = 0;
   localparam int VIOL_MEM   = 1;
   localparam int VIOL_EXEC  = 2;
   localparam int VIOL_ENTRY = 3;

endpackage

// File: rtl/omsp_viol_regs.sv
// Violation register file: sticky causes, OVF flag, PC/ID capture, peripheral read mux.
// Latency: state updates one mclk after the strobe/write; per_dout is combinational.
// Backpressure: none, strobes and bus accesses are taken every cycle.
//
// Ports: mclk/puc_rst_n clock and async reset; viol_src/pc/sm_id violation inputs;
// ovf_set (violation while handler active) and wr_block (ignore writes) from the FSM;
// per_* openMSP430 peripheral bus; causes_any/ovf status back to the FSM.
module omsp_viol_regs
   import omsp_viol_pkg::*;
#(
   parameter int          NUM_SRC   = 4,
   parameter logic [14:0] BASE_ADDR = 15'h0190
) (
   input  logic               mclk,
   input  logic               puc_rst_n,
   input  logic [NUM_SRC-1:0] viol_src,
   input  logic [15:0]        pc,
   input  logic [15:0]        sm_id,
   input  logic               ovf_set,
   input  logic               wr_block,
   input  logic               per_en,
   input  logic [1:0]         per_we,
   input  logic [13:0]        per_addr,
   input  logic [15:0]        per_din,
   output logic [15:0]        per_dout,
   output logic               causes_any,
   output logic               ovf
);

   localparam logic [13:0] BASE_WADDR = 14'(BASE_ADDR >> 1);

   logic [NUM_SRC-1:0] causes;
   logic [15:0]        pc_capt;
   logic [15:0]        id_capt;
   logic [13:0]        reg_off;
   logic               rd_en;
   logic               wr_status;
   logic [NUM_SRC-1:0] cause_clr;
   logic               ovf_clr;
   logic               unused_din;

   assign reg_off   = per_addr - BASE_WADDR;
   assign rd_en     = per_en & ~|per_we;
   assign wr_status = per_en & |per_we & ~wr_block & (reg_off == 14'(REG_STATUS));

   // Causes live in the low byte (NUM_SRC <= 8), OVF in the high byte.
   assign cause_clr  = {NUM_SRC{wr_status & per_we[0]}} & per_din[NUM_SRC-1:0];
   assign ovf_clr    = wr_status & per_we[1] & per_din[OVF_BIT];
   assign unused_din = ^per_din[OVF_BIT-1:NUM_SRC];

   assign causes_any = |causes;

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         causes  <= '0;
         ovf     <= 1'b0;
         pc_capt <= '0;
         id_capt <= '0;
      end else begin
         // Set after clear so a same-cycle strobe wins over W1C.
         causes <= (causes & ~cause_clr) | viol_src;
         ovf    <= (ovf & ~ovf_clr) | ovf_set;
         // Only the first violation of an episode is captured; the check uses
         // the registered causes, so a strobe racing a clear does not re-capture.
         if (|viol_src && !causes_any) begin
            pc_capt <= pc;
            id_capt <= sm_id;
         end
      end
   end

   always_comb begin
      per_dout = '0;
      if (rd_en) begin
         case (reg_off)
            14'(REG_STATUS): begin
               per_dout[NUM_SRC-1:0] = causes;
               per_dout[OVF_BIT]     = ovf;
            end
            14'(REG_PC_CAPT): per_dout = pc_capt;
            14'(REG_ID_CAPT): per_dout = id_capt;
            default:          per_dout = '0;
         endcase
      end
   end

endmodule

// File: rtl/omsp_violation_handler.sv
// Security-violation collector: latches causes, raises violation_irq, escalates to reset_req.
// Latency: irq one mclk after strobe; reset_req ESC_TIMEOUT cycles after ack without clear.
// Backpressure: none, strobes and irq_acc are single-cycle and always accepted.
//
// Ports: mclk/puc_rst_n clock and async reset; viol_src violation strobes (bit 0 atomicity);
// pc/sm_id capture sources; irq_acc interrupt acknowledge; per_* peripheral bus;
// violation_irq interrupt request; reset_req PUC request to the reset generator.
module omsp_violation_handler
   import omsp_viol_pkg::*;
#(
   parameter int          NUM_SRC     = 4,
   parameter int          ESC_TIMEOUT = 16,
   parameter logic [14:0] BASE_ADDR   = 15'h0190
) (
   input  logic               mclk,
   input  logic               puc_rst_n,
   input  logic [NUM_SRC-1:0] viol_src,
   input  logic [15:0]        pc,
   input  logic [15:0]        sm_id,
   input  logic               irq_acc,
   input  logic               per_en,
   input  logic [1:0]         per_we,
   input  logic [13:0]        per_addr,
   input  logic [15:0]        per_din,
   output logic [15:0]        per_dout,
   output logic               violation_irq,
   output logic               reset_req
);

   // Keep at least one bit so ESC_TIMEOUT = 1 still elaborates.
   localparam int             CNT_W    = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ESC_TIMEOUT - 1);

   viol_state_e      state, state_nxt;
   logic [CNT_W-1:0] esc_cnt, esc_cnt_nxt;
   logic             viol_any;
   logic             active;
   logic             causes_any;
   logic             ovf;
   logic             double_fault;

   assign viol_any     = |viol_src;
   assign active       = (state == ST_NOTIFY) || (state == ST_WAIT_CLR);
   assign double_fault = active & viol_any & ovf;

   omsp_viol_regs #(
      .NUM_SRC   (NUM_SRC),
      .BASE_ADDR (BASE_ADDR)
   ) u_regs (
      .mclk       (mclk),
      .puc_rst_n  (puc_rst_n),
      .viol_src   (viol_src),
      .pc         (pc),
      .sm_id      (sm_id),
      .ovf_set    (active & viol_any),
      .wr_block   (state == ST_RESET),
      .per_en     (per_en),
      .per_we     (per_we),
      .per_addr   (per_addr),
      .per_din    (per_din),
      .per_dout   (per_dout),
      .causes_any (causes_any),
      .ovf        (ovf)
   );

   always_comb begin
      state_nxt   = state;
      esc_cnt_nxt = esc_cnt;
      case (state)
         ST_IDLE: begin
            if (viol_any) state_nxt = ST_NOTIFY;
         end
         ST_NOTIFY: begin
            if (double_fault) begin
               state_nxt = ST_RESET;
            end else if (!causes_any) begin
               state_nxt = ST_IDLE;
            end else if (irq_acc) begin
               state_nxt   = ST_WAIT_CLR;
               esc_cnt_nxt = CNT_LOAD;
            end
         end
         ST_WAIT_CLR: begin
            if (double_fault) begin
               state_nxt = ST_RESET;
            end else if (!causes_any) begin
               state_nxt = ST_IDLE;
            end else if (esc_cnt == '0) begin
               state_nxt = ST_RESET;
            end else begin
               esc_cnt_nxt = esc_cnt - CNT_W'(1);
            end
         end
         ST_RESET: begin
            // Only puc_rst_n leaves this state.
            state_nxt = ST_RESET;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         state   <= ST_IDLE;
         esc_cnt <= '0;
      end else begin
         state   <= state_nxt;
         esc_cnt <= esc_cnt_nxt;
      end
   end

   assign violation_irq = (state == ST_NOTIFY);
   assign reset_req     = (state == ST_RESET);

endmodule

// File: tb/tb_omsp_violation_handler.sv
module tb_omsp_violation_handler;

   localparam int          ESC_T = 16;
   localparam logic [13:0] WBASE = 14'h00C8;

   logic        mclk = 1'b0;
   logic        puc_rst_n;
   logic [3:0]  viol_src;
   logic [15:0] pc;
   logic [15:0] sm_id;
   logic        irq_acc;
   logic        per_en;
   logic [1:0]  per_we;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic [15:0] per_dout;
   logic        violation_irq;
   logic        reset_req;

   always #5 mclk = ~mclk;

   omsp_violation_handler #(
      .NUM_SRC     (4),
      .ESC_TIMEOUT (ESC_T),
      .BASE_ADDR   (15'h0190)
   ) dut (
      .mclk          (mclk),
      .puc_rst_n     (puc_rst_n),
      .viol_src      (viol_src),
      .pc            (pc),
      .sm_id         (sm_id),
      .irq_acc       (irq_acc),
      .per_en        (per_en),
      .per_we        (per_we),
      .per_addr      (per_addr),
      .per_din       (per_din),
      .per_dout      (per_dout),
      .violation_irq (violation_irq),
      .reset_req     (reset_req)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        irq;
      logic        rreq;
      logic [15:0] dout;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: episode flags plus an absolute escalation deadline.
   logic [3:0]  m_causes;
   logic        m_ovf;
   logic [15:0] m_pc, m_id;
   bit          m_active, m_acked, m_rst;
   int          m_deadline;
   int          cyc = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      m_causes = '0; m_ovf = 1'b0; m_pc = '0; m_id = '0;
      m_active = 0; m_acked = 0; m_rst = 0; m_deadline = 0;
   endfunction

   function automatic logic [15:0] model_dout(input logic en, input logic [1:0] we,
                                              input logic [13:0] addr);
      logic [13:0] off;
      off = addr - WBASE;
      if (!en || we != 2'b00) return 16'h0000;
      case (off)
         14'd0:   return {m_ovf, 11'd0, m_causes};
         14'd1:   return m_pc;
         14'd2:   return m_id;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic void model_step(input logic [3:0] v, input logic [15:0] p,
                                      input logic [15:0] id, input logic acc, input logic en,
                                      input logic [1:0] we, input logic [13:0] addr,
                                      input logic [15:0] din);
      bit         wr_st;
      logic [3:0] clr;
      bit         oclr;
      logic [3:0] n_causes;
      logic       n_ovf;
      wr_st = en && (we != 2'b00) && (addr == WBASE) && !m_rst;
      clr   = (wr_st && we[0]) ? din[3:0] : 4'h0;
      oclr  = wr_st && we[1] && din[15];
      if (v != 0 && m_causes == 0) begin
         m_pc = p;
         m_id = id;
      end
      n_causes = (m_causes & ~clr) | v;
      n_ovf    = (m_ovf && !oclr) || (v != 0 && m_active);
      if (m_rst) begin
      end else if (!m_active) begin
         if (v != 0) begin m_active = 1; m_acked = 0; end
      end else if (v != 0 && m_ovf) begin
         m_active = 0; m_rst = 1;
      end else if (m_causes == 0) begin
         m_active = 0;
      end else if (!m_acked) begin
         if (acc) begin m_acked = 1; m_deadline = cyc + ESC_T; end
      end else if (cyc >= m_deadline) begin
         m_active = 0; m_rst = 1;
      end
      m_causes = n_causes;
      m_ovf    = n_ovf;
   endfunction

   // Drive one cycle of inputs and queue the outputs the model expects for it.
   task automatic cycle(input logic [3:0] v, input logic [15:0] p, input logic [15:0] id,
                        input logic acc, input logic en, input logic [1:0] we,
                        input logic [13:0] addr, input logic [15:0] din);
      exp_t e;
      @(posedge mclk); #1;
      puc_rst_n = 1'b1;
      viol_src = v; pc = p; sm_id = id; irq_acc = acc;
      per_en = en; per_we = we; per_addr = addr; per_din = din;
      e.irq  = m_active && !m_acked;
      e.rreq = m_rst;
      e.dout = model_dout(en, we, addr);
      exp_q.push_back(e);
      model_step(v, p, id, acc, en, we, addr, din);
      cyc++;
   endtask

   task automatic idle();
      cycle(4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 14'h0, 16'h0);
   endtask
   task automatic viol(input logic [3:0] v, input logic [15:0] p, input logic [15:0] id);
      cycle(v, p, id, 1'b0, 1'b0, 2'b00, 14'h0, 16'h0);
   endtask
   task automatic ack();
      cycle(4'h0, 16'h0, 16'h0, 1'b1, 1'b0, 2'b00, 14'h0, 16'h0);
   endtask
   task automatic rd(input logic [13:0] off);
      cycle(4'h0, 16'h0, 16'h0, 1'b0, 1'b1, 2'b00, WBASE + off, 16'h0);
   endtask
   task automatic wr_status(input logic [15:0] d, input logic [3:0] v);
      cycle(v, 16'h0, 16'h0, 1'b0, 1'b1, 2'b11, WBASE, d);
   endtask

   // Asynchronous reset in mid-cycle with a STATUS read pending.
   task automatic do_reset();
      exp_t e;
      @(posedge mclk); #1;
      viol_src = '0; pc = '0; sm_id = '0; irq_acc = 1'b0;
      per_en = 1'b1; per_we = 2'b00; per_addr = WBASE; per_din = '0;
      puc_rst_n = 1'b0;
      #1;
      chk("async_irq", 16'(violation_irq), 16'h0);
      chk("async_reset_req", 16'(reset_req), 16'h0);
      chk("async_status", per_dout, 16'h0);
      model_clear();
      e.irq = 1'b0; e.rreq = 1'b0; e.dout = 16'h0;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge mclk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_violation_irq", 16'(violation_irq), 16'(mon_e.irq));
            chk("sb_reset_req", 16'(reset_req), 16'(mon_e.rreq));
            chk("sb_per_dout", per_dout, mon_e.dout);
         end
      end
   end

   initial begin
      int rst_cycles;
      logic [3:0]  v;
      logic        acc;
      logic        en;
      logic [1:0]  we;
      logic [13:0] addr;
      logic [15:0] din;
      int          kind;

      puc_rst_n = 1'b0;
      viol_src = '0; pc = '0; sm_id = '0; irq_acc = 1'b0;
      per_en = 1'b0; per_we = '0; per_addr = '0; per_din = '0;
      model_clear();
      #2;
      chk("rst_violation_irq", 16'(violation_irq), 16'h0);
      chk("rst_reset_req", 16'(reset_req), 16'h0);
      do_reset();

      // First capture
      viol(4'b0001, 16'hA01C, 16'd3);
      rd(14'd0); @(negedge mclk);
      chk("cap_status", per_dout, 16'h0001);
      chk("cap_irq", 16'(violation_irq), 16'h1);
      rd(14'd1); @(negedge mclk); chk("cap_pc", per_dout, 16'hA01C);
      rd(14'd2); @(negedge mclk); chk("cap_id", per_dout, 16'd3);

      // Acknowledge then clear five cycles later
      ack();
      idle(); @(negedge mclk); chk("ack_irq_drop", 16'(violation_irq), 16'h0);
      idle(); idle(); idle();
      wr_status(16'h0001, 4'h0);
      idle();
      rd(14'd0); @(negedge mclk); chk("clr_status", per_dout, 16'h0000);
      for (int i = 0; i < 20; i++) idle();
      @(negedge mclk); chk("clr_no_reset", 16'(reset_req), 16'h0);

      // Escalation without clear
      viol(4'b0010, 16'h0BEE, 16'd7);
      ack();
      for (int i = 1; i <= ESC_T; i++) begin
         idle(); @(negedge mclk); chk("esc_early", 16'(reset_req), 16'h0);
      end
      idle(); @(negedge mclk); chk("esc_fire", 16'(reset_req), 16'h1);
      wr_status(16'h800F, 4'h0);
      rd(14'd0); @(negedge mclk);
      chk("esc_write_ignored", per_dout, 16'h0002);
      chk("esc_hold", 16'(reset_req), 16'h1);
      do_reset();
      rd(14'd0); @(negedge mclk); chk("post_rst_status", per_dout, 16'h0000);

      // Overflow then double fault
      viol(4'b0001, 16'h1111, 16'd5);
      viol(4'b0010, 16'h2222, 16'd6);
      rd(14'd0); @(negedge mclk); chk("ovf_status", per_dout, 16'h8003);
      rd(14'd1); @(negedge mclk); chk("ovf_pc_kept", per_dout, 16'h1111);
      viol(4'b0100, 16'h3333, 16'd7);
      idle(); @(negedge mclk); chk("dbl_reset", 16'(reset_req), 16'h1);
      idle(); @(negedge mclk); chk("dbl_hold", 16'(reset_req), 16'h1);
      do_reset();
      idle(); @(negedge mclk); chk("dbl_after_rst", 16'(reset_req), 16'h0);

      // Same-cycle set and clear of bit 0
      viol(4'b0001, 16'h4444, 16'd1);
      ack();
      wr_status(16'h0001, 4'b0001);
      rd(14'd0); @(negedge mclk); chk("setwins_status", per_dout, 16'h8001);
      rd(14'd1); @(negedge mclk); chk("setwins_pc", per_dout, 16'h4444);
      wr_status(16'h800F, 4'h0);
      idle();
      rd(14'd0); @(negedge mclk); chk("setwins_cleared", per_dout, 16'h0000);
      do_reset();

      // Randomized phase
      rst_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
         if (m_rst && rst_cycles >= 3) begin
            do_reset();
            rst_cycles = 0;
            continue;
         end
         if (m_rst) rst_cycles++;
         v   = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         acc = (m_active && !m_acked) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         kind = $urandom_range(0, 19);
         en = 1'b0; we = 2'($urandom_range(0, 3)); addr = WBASE; din = 16'($urandom);
         if (kind < 8) begin
            en = 1'b1; we = 2'b00; addr = WBASE + 14'($urandom_range(0, 3));
         end else if (kind == 8) begin
            en = 1'b1; we = 2'($urandom_range(1, 3)); addr = WBASE + 14'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) din = 16'h800F;
         end
         cycle(v, 16'($urandom), 16'($urandom), acc, en, we, addr, din);
      end

      @(negedge mclk); #1;
      chk("queue_drained", 16'(exp_q.size()), 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
